button_debouncer: RTL and testbench

//  - Per-channel synchroniser and debouncer for raw push-button pins (DE-board KEY[3:0], active-low).
//  - Drives the in_port of the buttons PIO with clean, active-high, glitch-free levels.
//  - Also drives one-cycle press/release strobes for hardware consumers.
//  - Placement: directly upstream of the PIO's edge-capture logic, so each physical press sets exactly one edge_capture bit.

---
 rtl/button_debouncer_pkg.sv | 22 ++
 rtl/button_debouncer_if.sv | 26 ++
 rtl/button_debouncer_channel.sv | 80 ++++++++
 rtl/button_debouncer.sv | 65 ++++++
 tb/tb_button_debouncer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared constants, types and helpers for the push-button debouncer.
// Imported by the top level and by every channel instance.
package btn_pkg;

  localparam int DEF_SAMPLE_DIV   = 1000;
  localparam int DEF_STABLE_TICKS = 250;

  typedef struct packed {
    logic level;
    logic press;
    logic rls;
  } chan_out_t;

  function automatic logic idle_level(input int active_low);
    return (active_low != 0) ? 1'b1 : 1'b0;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button bundle between the board pins and the debouncer.
// master = the side driving raw pins, slave = the debouncer.
interface button_debouncer_if #(
  parameter int N_CH = 4
);

  logic [N_CH-1:0] btn_raw;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] btn_press;
  logic [N_CH-1:0] btn_release;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );

endinterface

// File: rtl/button_debouncer_channel.sv
// One debounce channel: 2-FF synchroniser, stability counter, accepted state
// and registered level/press/release outputs.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int ACTIVE_LOW   = 1,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_tick,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rls
);

  localparam int            CW       = cnt_width(STABLE_TICKS);
  localparam logic          IDLE     = idle_level(ACTIVE_LOW);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  chan_out_t     out_q, out_d;
  logic          accept_s;
  logic          pressed_s;

  // Next-state logic: synchroniser shift, stability count and acceptance.
  always_comb begin
    s1_d     = raw;
    s2_d     = s1_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_s = 1'b0;
    if (sample_tick) begin
      if (s2_q == state_q) begin
        cnt_d = CNT_ZERO;
      end else if (cnt_q == CNT_LAST) begin
        state_d  = s2_q;
        cnt_d    = CNT_ZERO;
        accept_s = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
    // Outputs load from the next state so the strobe lands with the new level.
    pressed_s   = (ACTIVE_LOW != 0) ? ~state_d : state_d;
    out_d.level = pressed_s;
    out_d.press = accept_s & pressed_s;
    out_d.rls   = accept_s & ~pressed_s;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= IDLE;
      s2_q    <= IDLE;
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      out_q   <= chan_out_t'(3'b000);
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign level = out_q.level;
  assign press = out_q.press;
  assign rls   = out_q.rls;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer: a shared sample-tick prescaler feeding
// N_CH independent debounce channels.
module button_debouncer
  import btn_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int SAMPLE_DIV   = DEF_SAMPLE_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic               clk,
  input  logic               reset,
  button_debouncer_if.slave  bus
);

  localparam int            PW         = cnt_width(SAMPLE_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SAMPLE_DIV - 1);
  localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PRESC_ONE  = {{(PW-1){1'b0}}, 1'b1};

  logic [PW-1:0]   presc_q, presc_d;
  logic            sample_tick_s;
  logic [N_CH-1:0] level_s;
  logic [N_CH-1:0] press_s;
  logic [N_CH-1:0] rls_s;

  // With SAMPLE_DIV = 1 the count stays at 0 == PRESC_LAST, so the tick is constant.
  always_comb begin
    sample_tick_s = (presc_q == PRESC_LAST);
    if (sample_tick_s) begin
      presc_d = PRESC_ZERO;
    end else begin
      presc_d = presc_q + PRESC_ONE;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= PRESC_ZERO;
    end else begin
      presc_q <= presc_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .ACTIVE_LOW   (ACTIVE_LOW),
      .STABLE_TICKS (STABLE_TICKS)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .sample_tick (sample_tick_s),
      .raw         (bus.btn_raw[g]),
      .level       (level_s[g]),
      .press       (press_s[g]),
      .rls         (rls_s[g])
    );
  end

  assign bus.btn_level   = level_s;
  assign bus.btn_press   = press_s;
  assign bus.btn_release = rls_s;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: two instances (every-cycle sampling and
// prescaled) driven by a segment table, checked against a sliding-window model.
module tb_button_debouncer;

  logic       clk;
  logic       reset;
  logic [3:0] raw;

  button_debouncer_if #(.N_CH(4)) bus_a ();
  button_debouncer_if #(.N_CH(4)) bus_b ();

  assign bus_a.btn_raw = raw;
  assign bus_b.btn_raw = raw;

  button_debouncer #(
    .N_CH(4), .ACTIVE_LOW(1), .SAMPLE_DIV(1), .STABLE_TICKS(4)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  button_debouncer #(
    .N_CH(4), .ACTIVE_LOW(1), .SAMPLE_DIV(5), .STABLE_TICKS(3)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
  } exp_t;

  typedef struct {
    logic [3:0] raw;
    int         len;
    logic [3:0] lvl_a;
    logic [3:0] lvl_b;
  } seg_t;

  exp_t sb[$];
  seg_t segs[15];

  // Reference model: per instance a 2-deep pin delay, a tick counter and a
  // window of the most recent tick samples; a level flips when the whole
  // window disagrees with it.
  int         m_div[2];
  int         m_st[2];
  int         m_p[2];
  logic [3:0] m_s1[2];
  logic [3:0] m_s2[2];
  logic [3:0] m_state[2];
  logic [3:0] m_win[2][8];

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_p[n]     = 0;
      m_s1[n]    = 4'hF;
      m_s2[n]    = 4'hF;
      m_state[n] = 4'hF;
      for (int i = 0; i < 8; i++) m_win[n][i] = 4'hF;
    end
  endtask

  task automatic model_edge(input logic [3:0] r, output logic [11:0] ea, output logic [11:0] eb);
    logic [11:0] e[2];
    for (int n = 0; n < 2; n++) begin
      logic       tick;
      logic [3:0] smp;
      logic [3:0] prs;
      logic [3:0] rel;
      logic       all_diff;
      tick = (m_p[n] == m_div[n] - 1);
      smp  = m_s2[n];
      m_p[n]  = tick ? 0 : m_p[n] + 1;
      m_s2[n] = m_s1[n];
      m_s1[n] = r;
      prs = 4'h0;
      rel = 4'h0;
      if (tick) begin
        for (int i = 7; i > 0; i--) m_win[n][i] = m_win[n][i-1];
        m_win[n][0] = smp;
        for (int c = 0; c < 4; c++) begin
          all_diff = 1'b1;
          for (int i = 0; i < m_st[n]; i++)
            if (m_win[n][i][c] == m_state[n][c]) all_diff = 1'b0;
          if (all_diff) begin
            m_state[n][c] = ~m_state[n][c];
            if (m_state[n][c] == 1'b0) prs[c] = 1'b1;
            else                       rel[c] = 1'b1;
          end
        end
      end
      e[n] = {~m_state[n], prs, rel};
    end
    ea = e[0];
    eb = e[1];
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (level,press,release) at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] act_a();
    return {bus_a.btn_level, bus_a.btn_press, bus_a.btn_release};
  endfunction

  function automatic logic [11:0] act_b();
    return {bus_b.btn_level, bus_b.btn_press, bus_b.btn_release};
  endfunction

  // Called at a falling edge: drive, predict, clock, compare, return at next falling edge.
  task automatic do_cycle(input logic [3:0] r);
    exp_t e;
    raw = r;
    model_edge(r, e.a, e.b);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      check("cycle_a", act_a(), e.a);
      check("cycle_b", act_b(), e.b);
    end
    @(negedge clk);
  endtask

  initial begin
    m_div[0] = 1; m_st[0] = 4;
    m_div[1] = 5; m_st[1] = 3;

    //            raw    len lvl_a  lvl_b
    segs[0]  = '{4'hF, 20, 4'h0, 4'h0};   // idle after reset
    segs[1]  = '{4'hE, 10, 4'h1, 4'h0};   // clean press ch0
    segs[2]  = '{4'hF, 10, 4'h0, 4'h0};   // release ch0
    segs[3]  = '{4'hD,  3, 4'h0, 4'h0};   // bounce ch1
    segs[4]  = '{4'hF,  1, 4'h0, 4'h0};
    segs[5]  = '{4'hD,  3, 4'h0, 4'h0};
    segs[6]  = '{4'hF,  6, 4'h0, 4'h0};
    segs[7]  = '{4'hD,  8, 4'h2, 4'h0};   // real press ch1
    segs[8]  = '{4'hF,  8, 4'h0, 4'h0};
    segs[9]  = '{4'h0, 10, 4'hF, 4'h0};   // all channels together
    segs[10] = '{4'hF, 10, 4'h0, 4'h0};
    segs[11] = '{4'h7, 10, 4'h8, 4'h0};   // two-tick glitch for prescaled instance
    segs[12] = '{4'hF, 20, 4'h0, 4'h0};
    segs[13] = '{4'h7, 25, 4'h8, 4'h8};   // long press seen by both
    segs[14] = '{4'hF, 25, 4'h0, 4'h0};

    raw   = 4'hF;
    reset = 1'b0;
    model_reset();

    // Asynchronous reset asserted between clock edges.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("reset_async_a", act_a(), 12'h000);
    check("reset_async_b", act_b(), 12'h000);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_a", act_a(), 12'h000);
    @(negedge clk);
    reset = 1'b0;

    for (int s = 0; s < 15; s++) begin
      for (int k = 0; k < segs[s].len; k++) do_cycle(segs[s].raw);
      check($sformatf("seg%0d_level_a", s), {8'h00, bus_a.btn_level}, {8'h00, segs[s].lvl_a});
      check($sformatf("seg%0d_level_b", s), {8'h00, bus_b.btn_level}, {8'h00, segs[s].lvl_b});
    end

    // Exact latency of a clean press on ch0: strobe on the 6th edge only.
    for (int k = 0; k < 5; k++) do_cycle(4'hE);
    check("lat_before_a", act_a(), 12'h000);
    do_cycle(4'hE);
    check("lat_edge_a", act_a(), 12'h110);
    do_cycle(4'hE);
    check("lat_after_a", act_a(), 12'h100);
    for (int k = 0; k < 20; k++) do_cycle(4'hF);

    // Reset in the middle of a count on ch2, button held through reset.
    for (int k = 0; k < 3; k++) do_cycle(4'hB);
    #2 reset = 1'b1;
    #1;
    check("midcnt_reset_a", act_a(), 12'h000);
    model_reset();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check("midcnt_hold_a", act_a(), 12'h000);
      check("midcnt_hold_b", act_b(), 12'h000);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) do_cycle(4'hB);
    check("midcnt_exit5_a", act_a(), 12'h000);
    do_cycle(4'hB);
    check("midcnt_exit6_a", act_a(), 12'h440);
    for (int k = 0; k < 20; k++) do_cycle(4'hF);
    check("final_a", act_a(), 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
